dac_arbiter: RTL



---
 rtl/dac_arbiter_pkg.sv | 24 ++
 rtl/dac_arbiter_if.sv | 15 +
 rtl/dac_arbiter_rr_pick.sv | 23 ++
 rtl/dac_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dac_arbiter_pkg.sv
// Shared types and constants for the MCP4725 request arbiter.
package dac_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_END   = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  typedef enum logic {
    JOB_UPDATE = 1'b0,
    JOB_MEMWR  = 1'b1
  } job_e;

  localparam logic [3:0] MEM_ID = 4'd15;
  localparam int         CNT_W  = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dac_arbiter_if.sv
// Arbiter <-> mcp4725 control/status bundle.
interface dac_arbiter_if;
  logic [11:0] data;
  logic [1:0]  mode;
  logic        enable;
  logic        wr_mem;
  logic        scl;
  logic [11:0] data_reg;
  logic [1:0]  mode_reg;

  modport master (output data, mode, enable, wr_mem,
                  input  scl, data_reg, mode_reg);
  modport slave  (input  data, mode, enable, wr_mem,
                  output scl, data_reg, mode_reg);
endinterface

// File: rtl/dac_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic                    vld_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);
  localparam int IW = $clog2(NREQ);

  // Scan farthest-first so the nearest requester after last_i wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    for (int off = NREQ; off >= 1; off--) begin
      if (req_i[IW'((int'(last_i) + off) % NREQ)]) begin
        vld_o = 1'b1;
        idx_o = IW'((int'(last_i) + off) % NREQ);
      end
    end
  end
endmodule

// File: rtl/dac_arbiter.sv
// Shares one mcp4725 between NREQ update requesters and one EEPROM-write requester,
// tracking transaction start/end from SCL activity.
module dac_arbiter
  import dac_arbiter_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int QUIET_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [12*NREQ-1:0]   req_data_i,
  input  logic [2*NREQ-1:0]    req_mode_i,
  input  logic                 mem_req_i,
  input  logic [11:0]          mem_data_i,
  input  logic [1:0]           mem_mode_i,
  output logic [NREQ-1:0]      ack_o,
  output logic                 mem_ack_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic [3:0]           gnt_id_o,
  dac_arbiter_if.master        dac
);
  localparam int IW = $clog2(NREQ);

  state_e           state_q, state_d;
  job_e             job_q, job_d;
  logic [11:0]      data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CNT_W-1:0] tmo_q, tmo_d, quiet_q, quiet_d;
  logic             err_q, err_d;
  logic             pick_vld, skip, tmo_hit;
  logic [IW-1:0]    pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

  // An unchanged update would never start a transaction on the device.
  assign skip    = (job_q == JOB_UPDATE) && (data_q == dac.data_reg) && (mode_q == dac.mode_reg);
  assign tmo_hit = tmo_q >= CNT_W'(TIMEOUT_CYCLES - 1);

  assign dac.data = data_q;
  assign dac.mode = mode_q;
  assign busy_o   = (state_q != S_IDLE);
  assign gnt_id_o = gnt_q;

  always_comb begin
    state_d    = state_q;
    job_d      = job_q;
    data_d     = data_q;
    mode_d     = mode_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    err_d      = err_q;
    quiet_d    = '0;
    dac.enable = 1'b0;
    dac.wr_mem = 1'b0;
    ack_o      = '0;
    mem_ack_o  = 1'b0;
    err_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          state_d = S_ISSUE;
          job_d   = JOB_MEMWR;
          gnt_d   = MEM_ID;
          data_d  = mem_data_i;
          mode_d  = mem_mode_i;
          err_d   = 1'b0;
        end else if (pick_vld) begin
          state_d = S_ISSUE;
          job_d   = JOB_UPDATE;
          gnt_d   = 4'(pick_idx);
          data_d  = req_data_i[12*int'(pick_idx) +: 12];
          mode_d  = req_mode_i[2*int'(pick_idx) +: 2];
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        dac.enable = !skip;
        dac.wr_mem = (job_q == JOB_MEMWR);
        state_d    = skip ? S_DONE : S_WAIT_START;
      end
      S_WAIT_START: begin
        dac.enable = 1'b1;
        if (!dac.scl) begin
          state_d = S_WAIT_END;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_WAIT_END: begin
        // SCL parked high long enough means the device released the bus.
        quiet_d = dac.scl ? sat_inc(quiet_q) : '0;
        if (quiet_d == CNT_W'(QUIET_CYCLES)) begin
          state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_o   = err_q;
        if (job_q == JOB_MEMWR) begin
          mem_ack_o = 1'b1;
        end else begin
          ack_o[gnt_q[IW-1:0]] = 1'b1;
          last_d               = gnt_q[IW-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    tmo_d = (state_d != state_q) ? '0 : sat_inc(tmo_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      job_q   <= JOB_UPDATE;
      data_q  <= '0;
      mode_q  <= '0;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      tmo_q   <= '0;
      quiet_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      quiet_q <= quiet_d;
      err_q   <= err_d;
    end
  end

endmodule
